// File: rtl/axi_read_responder.sv
// axi_read_responder: AR/R read endpoint over a word-addressed memory with fixed access latency.
// Define AXI_READ_RESPONDER_AR_SKID_EN to add a one-entry AR buffer for back-to-back replies.
module axi_read_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 256,
    parameter int LATENCY    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ar_valid,
    output logic                         ar_ready,
    input  logic [ADDR_WIDTH-1:0]        ar_addr,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [DATA_WIDTH-1:0]        r_data,
    output logic [1:0]                   r_resp,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata
);
    localparam int B  = $clog2(DATA_WIDTH / 8);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  err;
    logic [DATA_WIDTH-1:0] rd;
    logic                  ar_hs;
    logic                  r_hs;
    always_comb begin
        err = (addr & ADDR_WIDTH'((1 << B) - 1)) != '0 || (addr >> B) >= ADDR_WIDTH'(MEM_DEPTH);
        rd  = err ? '0 : mem[AW'(addr >> B)];
    end
    assign ar_hs = ar_valid && ar_ready;
    assign r_hs  = r_valid && r_ready;
`ifdef AXI_READ_RESPONDER_AR_SKID_EN
    logic                  full;
    logic [ADDR_WIDTH-1:0] skid_addr;
    assign ar_ready = !full && !rst;
`else
    assign ar_ready = state == IDLE && !rst;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_resp  <= 2'b00;
            cnt     <= '0;
            addr    <= '0;
`ifdef AXI_READ_RESPONDER_AR_SKID_EN
            full      <= 1'b0;
            skid_addr <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (ar_hs) begin
                    addr  <= ar_addr;
                    cnt   <= CW'(LATENCY - 1);
                    state <= ACCESS;
                end
                ACCESS: if (cnt == '0) begin
                    r_data  <= rd;
                    r_resp  <= err ? 2'b10 : 2'b00;
                    r_valid <= 1'b1;
                    state   <= RESP;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                RESP: if (r_hs) begin
                    r_valid <= 1'b0;
`ifdef AXI_READ_RESPONDER_AR_SKID_EN
                    if (full) begin
                        addr  <= skid_addr;
                        full  <= 1'b0;
                        cnt   <= CW'(LATENCY - 1);
                        state <= ACCESS;
                    end else if (ar_hs) begin
                        addr  <= ar_addr;
                        cnt   <= CW'(LATENCY - 1);
                        state <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
`ifdef AXI_READ_RESPONDER_AR_SKID_EN
            // A request arriving while busy waits in the buffer unless the reply retires this cycle.
            if (ar_hs && state != IDLE && !(state == RESP && r_hs)) begin
                full      <= 1'b1;
                skid_addr <= ar_addr;
            end
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we && 32'(mem_waddr) < MEM_DEPTH) mem[mem_waddr] <= mem_wdata;
    end
endmodule
